// File: rtl/apb_master_bridge_pkg.sv
// Shared types, default sizes and helpers for the APB master bridge.
package apb_master_bridge_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

    localparam int unsigned APB_DEF_DW      = 32;
    localparam int unsigned APB_DEF_AW      = 32;
    localparam int unsigned APB_DEF_NSLV    = 4;
    localparam int unsigned APB_DEF_SLV_LSB = 12;
    localparam int unsigned APB_DEF_TIMEOUT = 16;

    // Index/counter width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Request/response channel plus shared APB bus seen by the bridge (master) and its environment.
interface apb_master_bridge_if #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 32,
    parameter int unsigned NSLV = 4
) ();

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [AW-1:0]        req_addr;
    logic [DW-1:0]        req_wdata;
    logic                 rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_err;
    logic [AW-1:0]        pADDR;
    logic [NSLV-1:0]      pSEL;
    logic                 pENABLE;
    logic                 pWRITE;
    logic [DW-1:0]        pWDATA;
    logic [NSLV*DW-1:0]   pRDATA;
    logic [NSLV-1:0]      pREADY;
    logic [NSLV-1:0]      pSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, pRDATA, pREADY, pSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, pADDR, pSEL, pENABLE, pWRITE, pWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, pRDATA, pREADY, pSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, pADDR, pSEL, pENABLE, pWRITE, pWDATA
    );

endinterface

// File: rtl/apb_master_bridge_addr_decoder.sv
// Extracts the slave index field from a byte address and flags whether it names a real slave.
module apb_master_bridge_addr_decoder #(
    parameter int unsigned AW      = 32,
    parameter int unsigned NSLV    = 4,
    parameter int unsigned SLV_LSB = 12,
    parameter int unsigned SW      = 2
) (
    input  logic [AW-1:0] i_addr,
    output logic [SW-1:0] o_idx,
    output logic          o_hit
);

    logic w_unused_addr;

    assign o_idx = i_addr[SLV_LSB +: SW];
    assign o_hit = ({1'b0, o_idx} < (SW + 1)'(NSLV));

    // Only the index field matters; the rest of the address is deliberately ignored.
    assign w_unused_addr = ^i_addr;

endmodule

// File: rtl/apb_master_bridge.sv
// APB master bridge: turns a valid/ready request into APB SETUP/ACCESS transfers towards NSLV
// slaves, muxes the selected slave's reply back and aborts transfers that wait too long.
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int unsigned DW      = APB_DEF_DW,
    parameter int unsigned AW      = APB_DEF_AW,
    parameter int unsigned NSLV    = APB_DEF_NSLV,
    parameter int unsigned SLV_LSB = APB_DEF_SLV_LSB,
    parameter int unsigned TIMEOUT = APB_DEF_TIMEOUT
) (
    input logic                 pCLK,
    input logic                 pRESET,
    apb_master_bridge_if.master bus
);

    localparam int unsigned SW = clog2_min1(NSLV);
    localparam int unsigned CW = clog2_min1(TIMEOUT + 1);

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    apb_state_e    r_state;
    apb_state_e    w_state_next;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_write;
    logic [SW-1:0] r_idx;
    logic [CW-1:0] r_wait;
    logic [CW-1:0] w_wait_next;
    logic          r_rsp_valid;
    logic          w_rsp_valid_next;
    rsp_t          r_rsp;
    rsp_t          w_rsp_next;

    logic          w_accept;
    logic          w_hit;
    logic [SW-1:0] w_dec_idx;
    logic          w_sel_ready;
    logic          w_sel_err;
    logic [DW-1:0] w_sel_rdata;
    logic          w_timeout;
    logic [NSLV-1:0] w_psel;

    apb_master_bridge_addr_decoder #(
        .AW      (AW),
        .NSLV    (NSLV),
        .SLV_LSB (SLV_LSB),
        .SW      (SW)
    ) u_addr_decoder (
        .i_addr (bus.req_addr),
        .o_idx  (w_dec_idx),
        .o_hit  (w_hit)
    );

    assign w_sel_ready = bus.pREADY[r_idx];
    assign w_sel_err   = bus.pSLVERR[r_idx];
    assign w_sel_rdata = bus.pRDATA[r_idx*DW +: DW];

    // Fires on the ACCESS cycle whose miss would bring the wait count up to TIMEOUT.
    assign w_timeout = (TIMEOUT != 0) && ((r_wait + 1'b1) == CW'(TIMEOUT));

    always_comb begin
        w_state_next     = r_state;
        w_wait_next      = r_wait;
        w_rsp_valid_next = 1'b0;
        w_rsp_next       = r_rsp;
        w_accept         = 1'b0;
        unique case (r_state)
            APB_IDLE: begin
                if (bus.req_valid) begin
                    if (w_hit) begin
                        w_accept     = 1'b1;
                        w_state_next = APB_SETUP;
                    end else begin
                        w_rsp_valid_next = 1'b1;
                        w_rsp_next.rdata = '0;
                        w_rsp_next.err   = 1'b1;
                    end
                end
            end
            APB_SETUP: begin
                w_wait_next  = '0;
                w_state_next = APB_ACCESS;
            end
            APB_ACCESS: begin
                if (w_sel_ready) begin
                    w_state_next     = APB_IDLE;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_next.rdata = r_write ? '0 : w_sel_rdata;
                    w_rsp_next.err   = w_sel_err;
                end else if (w_timeout) begin
                    w_state_next     = APB_IDLE;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_next.rdata = '0;
                    w_rsp_next.err   = 1'b1;
                end else begin
                    w_wait_next = r_wait + 1'b1;
                end
            end
            default: begin
                w_state_next = APB_IDLE;
            end
        endcase
    end

    always_ff @(posedge pCLK) begin
        if (pRESET) begin
            r_state     <= APB_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_idx       <= '0;
            r_wait      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_wait      <= w_wait_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp       <= w_rsp_next;
            // Bus-side address/data only change on an accepted transfer so IDLE never toggles them.
            if (w_accept) begin
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_write <= bus.req_write;
                r_idx   <= w_dec_idx;
            end
        end
    end

    always_comb begin
        w_psel = '0;
        if (r_state != APB_IDLE) begin
            w_psel[r_idx] = 1'b1;
        end
    end

    assign bus.req_ready = (r_state == APB_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp.rdata;
    assign bus.rsp_err   = r_rsp.err;
    assign bus.pADDR     = r_addr;
    assign bus.pSEL      = w_psel;
    assign bus.pENABLE   = (r_state == APB_ACCESS);
    assign bus.pWRITE    = r_write;
    assign bus.pWDATA    = r_wdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus randomized back-to-back traffic
// checked against a cycle-count/response model of the bridge.
module tb_apb_master_bridge;

    localparam int TO = 16;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    apb_master_bridge_if #(.DW(32), .AW(32), .NSLV(4)) bus ();
    apb_master_bridge_if #(.DW(32), .AW(32), .NSLV(3)) bus3 ();

    apb_master_bridge #(
        .DW(32), .AW(32), .NSLV(4), .SLV_LSB(12), .TIMEOUT(TO)
    ) u_dut (
        .pCLK   (clk),
        .pRESET (rst),
        .bus    (bus)
    );

    apb_master_bridge #(
        .DW(32), .AW(32), .NSLV(3), .SLV_LSB(12), .TIMEOUT(TO)
    ) u_dut3 (
        .pCLK   (clk),
        .pRESET (rst),
        .bus    (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    // Selected slave gets the scenario values; every other slave gets noise that must be ignored.
    task automatic drive_slaves(input int idx, input logic rdy, input logic serr,
                                input logic [31:0] rdata);
        for (int s = 0; s < 4; s++) begin
            bus.pREADY[s]           = (s == idx) ? rdy : 1'($urandom);
            bus.pSLVERR[s]          = (s == idx) ? serr : 1'($urandom);
            bus.pRDATA[s*32 +: 32]  = (s == idx) ? rdata : $urandom;
        end
    endtask

    // Issues one request at the current cycle (cycle 0) and records what the DUT does.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic serr, input logic [31:0] rdata,
                           output int rsp_cyc, output logic [31:0] o_rdata, output logic o_err,
                           output logic [3:0] sel1, output logic en2, output logic rdy0,
                           output int bad, output logic [3:0] end_sel, output logic end_en);
        int         idx;
        logic [3:0] onehot;
        idx     = int'(addr[13:12]);
        onehot  = 4'b0001 << idx;
        rsp_cyc = -1;
        o_rdata = '0;
        o_err   = 1'b0;
        sel1    = '0;
        en2     = 1'b0;
        bad     = 0;
        end_sel = '1;
        end_en  = 1'b1;
        rdy0    = bus.req_ready;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        drive_slaves(idx, waits < -2, serr, rdata);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) begin
                rsp_cyc = c;
                o_rdata = bus.rsp_rdata;
                o_err   = bus.rsp_err;
                end_sel = bus.pSEL;
                end_en  = bus.pENABLE;
                bus.req_valid = 1'b0;
                break;
            end
            if (c == 1) sel1 = bus.pSEL;
            if (c == 2) en2 = bus.pENABLE;
            if (bus.pSEL !== onehot || bus.pADDR !== addr || bus.pWRITE !== wr ||
                bus.pWDATA !== wdata || bus.pENABLE !== (c >= 2)) bad++;
            // Request noise while busy must not disturb the transfer.
            bus.req_valid = 1'($urandom);
            bus.req_write = 1'($urandom);
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
            drive_slaves(idx, c >= 2 + waits, serr, rdata);
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus3.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.req_ready, bus.pSEL, bus.pENABLE, bus.pWRITE, bus.rsp_valid, bus.rsp_err}
            !== 9'b1_0000_0000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected %b", {bus.req_ready, bus.pSEL,
                     bus.pENABLE, bus.pWRITE, bus.rsp_valid, bus.rsp_err}, 9'b1_0000_0000);
        end
        checks++;
        if ({bus.pADDR, bus.pWDATA, bus.rsp_rdata} !== 96'h0) begin
            failures++;
            $display("FAIL reset_data: got %h expected 0", {bus.pADDR, bus.pWDATA, bus.rsp_rdata});
        end
        checks++;
        if ({bus3.req_ready, bus3.pSEL, bus3.pENABLE, bus3.rsp_valid, bus3.rsp_err}
            !== 7'b1_000_000) begin
            failures++;
            $display("FAIL reset_ctrl_nslv3: got %b expected %b", {bus3.req_ready, bus3.pSEL,
                     bus3.pENABLE, bus3.rsp_valid, bus3.rsp_err}, 7'b1_000_000);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_basic();
        int cyc, bad;
        logic [31:0] rd;
        logic err, en2, rdy0, end_en;
        logic [3:0] sel1, end_sel;
        run_txn(1'b1, 32'h0000_1000, 32'h1, 0, 1'b0, 32'h1234_5678,
                cyc, rd, err, sel1, en2, rdy0, bad, end_sel, end_en);
        checks++;
        if (sel1 !== 4'b0010) begin
            failures++;
            $display("FAIL write_psel_c1: got %b expected 0010", sel1);
        end
        checks++;
        if (en2 !== 1'b1) begin
            failures++;
            $display("FAIL write_penable_c2: got %b expected 1", en2);
        end
        checks++;
        if (cyc !== 3 || err !== 1'b0 || rd !== 32'h0) begin
            failures++;
            $display("FAIL write_rsp: got cyc=%0d err=%b rdata=%h expected cyc=3 err=0 rdata=0",
                     cyc, err, rd);
        end
        checks++;
        if (bad !== 0 || end_sel !== 4'b0 || end_en !== 1'b0) begin
            failures++;
            $display("FAIL write_bus: got bad=%0d sel=%b en=%b expected bad=0 sel=0000 en=0",
                     bad, end_sel, end_en);
        end
    endtask

    task automatic test_read_wait();
        int cyc, bad;
        logic [31:0] rd;
        logic err, en2, rdy0, end_en;
        logic [3:0] sel1, end_sel;
        run_txn(1'b0, 32'h0000_0004, 32'h0, 2, 1'b0, 32'hDEAD_BEEF,
                cyc, rd, err, sel1, en2, rdy0, bad, end_sel, end_en);
        checks++;
        if (cyc !== 5 || rd !== 32'hDEAD_BEEF || err !== 1'b0) begin
            failures++;
            $display("FAIL read_wait_rsp: got cyc=%0d rdata=%h err=%b expected 5 deadbeef 0",
                     cyc, rd, err);
        end
        checks++;
        if (sel1 !== 4'b0001 || bad !== 0) begin
            failures++;
            $display("FAIL read_wait_bus: got sel=%b bad=%0d expected 0001 0", sel1, bad);
        end
    endtask

    task automatic test_slverr();
        int cyc, bad;
        logic [31:0] rd;
        logic err, en2, rdy0, end_en;
        logic [3:0] sel1, end_sel;
        run_txn(1'b0, 32'h0000_2000, 32'h0, 0, 1'b1, 32'hDEAD_BEEF,
                cyc, rd, err, sel1, en2, rdy0, bad, end_sel, end_en);
        checks++;
        if (cyc !== 3 || err !== 1'b1 || rd !== 32'hDEAD_BEEF || sel1 !== 4'b0100) begin
            failures++;
            $display("FAIL slverr_rsp: got cyc=%0d err=%b rdata=%h sel=%b expected 3 1 deadbeef 0100",
                     cyc, err, rd, sel1);
        end
    endtask

    task automatic test_timeout();
        int cyc, bad;
        logic [31:0] rd;
        logic err, en2, rdy0, end_en;
        logic [3:0] sel1, end_sel;
        run_txn(1'b0, 32'h0000_3008, 32'h0, 1000, 1'b0, 32'hCAFE_F00D,
                cyc, rd, err, sel1, en2, rdy0, bad, end_sel, end_en);
        checks++;
        if (cyc !== 2 + TO || err !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL timeout_rsp: got cyc=%0d err=%b rdata=%h expected cyc=%0d err=1 rdata=0",
                     cyc, err, rd, 2 + TO);
        end
        checks++;
        if (end_sel !== 4'b0 || end_en !== 1'b0 || bad !== 0) begin
            failures++;
            $display("FAIL timeout_drop: got sel=%b en=%b bad=%0d expected 0000 0 0",
                     end_sel, end_en, bad);
        end
        bus.pREADY = '1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.pSEL !== 4'b0) begin
                failures++;
                $display("FAIL timeout_late_ready: got rsp_valid=%b sel=%b expected 0 0000",
                         bus.rsp_valid, bus.pSEL);
            end
        end
        bus.pREADY = '0;
    endtask

    task automatic test_decode_miss();
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a_miss;
            logic [31:0] a_hit;
            logic [31:0] rd;
            logic [2:0]  onehot;
            int          idx;
            idx    = k % 3;
            onehot = 3'b001 << idx;
            a_miss = $urandom;
            a_miss[13:12] = 2'd3;
            a_hit  = $urandom;
            a_hit[13:12] = 2'(idx);
            rd     = $urandom;
            bus3.pREADY  = '1;
            bus3.pSLVERR = '0;
            for (int s = 0; s < 3; s++) bus3.pRDATA[s*32 +: 32] = (s == idx) ? rd : $urandom;
            bus3.req_valid = 1'b1;
            bus3.req_write = 1'b0;
            bus3.req_addr  = a_miss;
            bus3.req_wdata = $urandom;
            @(posedge clk);
            #1;
            checks++;
            if ({bus3.rsp_valid, bus3.rsp_err, bus3.pSEL, bus3.req_ready} !== 6'b11_000_1 ||
                bus3.rsp_rdata !== 32'h0) begin
                failures++;
                $display("FAIL miss_rsp: got vld/err/sel/rdy=%b rdata=%h expected 110001 0",
                         {bus3.rsp_valid, bus3.rsp_err, bus3.pSEL, bus3.req_ready},
                         bus3.rsp_rdata);
            end
            bus3.req_addr = a_hit;
            @(posedge clk);
            #1;
            bus3.req_valid = 1'b0;
            checks++;
            if (bus3.pSEL !== onehot || bus3.rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL miss_next_setup: got sel=%b vld=%b expected %b 0",
                         bus3.pSEL, bus3.rsp_valid, onehot);
            end
            repeat (2) @(posedge clk);
            #1;
            checks++;
            if (bus3.rsp_valid !== 1'b1 || bus3.rsp_err !== 1'b0 || bus3.rsp_rdata !== rd) begin
                failures++;
                $display("FAIL miss_next_rsp: got vld=%b err=%b rdata=%h expected 1 0 %h",
                         bus3.rsp_valid, bus3.rsp_err, bus3.rsp_rdata, rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc, bad;
        logic [31:0] rd;
        logic err, en2, rdy0, end_en;
        logic [3:0] sel1, end_sel;
        bus.pREADY    = '0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0000_1010;
        bus.req_wdata = $urandom;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.pENABLE !== 1'b1 || bus.pSEL !== 4'b0010) begin
            failures++;
            $display("FAIL rstmid_access: got en=%b sel=%b expected 1 0010", bus.pENABLE, bus.pSEL);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.pSEL, bus.pENABLE, bus.rsp_valid} !== 6'b0) begin
            failures++;
            $display("FAIL rstmid_drop: got sel/en/vld=%b expected 000000",
                     {bus.pSEL, bus.pENABLE, bus.rsp_valid});
        end
        rst = 1'b0;
        bus.pREADY = '1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_no_rsp: got %b expected 0", bus.rsp_valid);
            end
        end
        bus.pREADY = '0;
        run_txn(1'b1, 32'h0000_3ABC, $urandom, 0, 1'b0, 32'h0,
                cyc, rd, err, sel1, en2, rdy0, bad, end_sel, end_en);
        checks++;
        if (cyc !== 3 || err !== 1'b0 || bad !== 0) begin
            failures++;
            $display("FAIL rstmid_after: got cyc=%0d err=%b bad=%0d expected 3 0 0", cyc, err, bad);
        end
    endtask

    task automatic test_back_to_back_random();
        for (int n = 0; n < 40; n++) begin
            int          cyc, bad, idx, waits, exp_cyc;
            logic [31:0] rd, addr, wdata, rdata, exp_rd;
            logic        err, en2, rdy0, end_en, wr, serr, timed_out, exp_err;
            logic [3:0]  sel1, end_sel;
            wr    = 1'($urandom);
            idx   = $urandom_range(0, 3);
            addr  = $urandom;
            addr[13:12] = 2'(idx);
            wdata = $urandom;
            rdata = $urandom;
            serr  = ($urandom_range(0, 3) == 0);
            waits = ($urandom_range(0, 9) == 0) ? TO - 1 + $urandom_range(0, 3)
                                                : $urandom_range(0, 5);
            timed_out = (waits >= TO);
            exp_cyc   = timed_out ? 2 + TO : 3 + waits;
            exp_err   = timed_out ? 1'b1 : serr;
            exp_rd    = (timed_out || wr) ? 32'h0 : rdata;
            run_txn(wr, addr, wdata, waits, serr, rdata,
                    cyc, rd, err, sel1, en2, rdy0, bad, end_sel, end_en);
            checks++;
            if (cyc !== exp_cyc || rdy0 !== 1'b1) begin
                failures++;
                $display("FAIL rand%0d_timing: got cyc=%0d rdy0=%b expected cyc=%0d rdy0=1",
                         n, cyc, rdy0, exp_cyc);
            end
            checks++;
            if (rd !== exp_rd || err !== exp_err) begin
                failures++;
                $display("FAIL rand%0d_rsp: got rdata=%h err=%b expected rdata=%h err=%b",
                         n, rd, err, exp_rd, exp_err);
            end
            checks++;
            if (bad !== 0 || end_sel !== 4'b0 || end_en !== 1'b0) begin
                failures++;
                $display("FAIL rand%0d_bus: got bad=%0d sel=%b en=%b expected 0 0000 0",
                         n, bad, end_sel, end_en);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.pRDATA     = '0;
        bus.pREADY     = '0;
        bus.pSLVERR    = '0;
        bus3.req_valid = 1'b0;
        bus3.req_write = 1'b0;
        bus3.req_addr  = '0;
        bus3.req_wdata = '0;
        bus3.pRDATA    = '0;
        bus3.pREADY    = '0;
        bus3.pSLVERR   = '0;
        test_reset();
        test_write_basic();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_decode_miss();
        test_reset_mid();
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
